uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial transmitter for the lab UART link: 8N1 framing, LSB first, fixed baud set by a clock-divider parameter.
- Sits between a byte producer (switch/keypad logic, test pattern source) and the board TX pin.
- It is the sending end of the link. The matching receiver samples this line through the existing two-flop DFF synchronizer.
- Output is fully registered, so the line never glitches between bits.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per serial bit (100 MHz / 9600 baud); must be >= 2.
- DATA_BITS, 8, payload bits per frame.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- tx_data  input  DATA_BITS  byte to send; sampled only in the accept cycle.
- tx_start  input  1  request; a level held high sends repeatedly, once per frame.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse on the final cycle of the stop bit.
- tx  output  1  serial line; idle high.

Behaviour:
- Reset (reset==0 at an edge):
  - tx=1, tx_busy=0, tx_done=0.
  - FSM goes to IDLE; bit counter and baud counter clear to 0; shift register clears to 0.
  - Reset mid-frame aborts the frame: tx returns to 1 on that same edge, and no tx_done is issued.
- FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - tx=1, tx_busy=0.
  - Accept edge: tx_start==1 is seen at a rising edge while in IDLE.
  - On the accept edge: tx_data is latched into the shift register, the FSM enters START, tx becomes 0, tx_busy becomes 1, and the baud counter is set to 0.
  - tx_start while not in IDLE is ignored; there is no queueing.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in START, DATA and STOP.
  - At CLKS_PER_BIT-1 it wraps to 0 and a bit-boundary event fires.
- START: tx=0 for exactly CLKS_PER_BIT cycles. At the bit boundary: go to DATA, drive tx = shift[0], bit counter = 0.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - At each boundary the shift register shifts right by 1 and the bit counter increments.
  - After bit index DATA_BITS-1 completes, go to STOP with tx=1.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the last cycle (baud count == CLKS_PER_BIT-1), tx_done=1 for exactly that cycle.
  - Next edge: IDLE, tx_busy=0.
- Timing:
  - tx_busy is high for exactly (DATA_BITS+2)*CLKS_PER_BIT cycles per frame.
  - Minimum gap between frames is 1 IDLE cycle. With tx_start held high, frames start every (DATA_BITS+2)*CLKS_PER_BIT+1 cycles.
  - Latency from the tx_start edge to the tx falling edge is 1 clock (registered).
- Widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits.
  - Bit counter: $clog2(DATA_BITS) bits; wraps harmlessly because the FSM leaves DATA at DATA_BITS-1.
- tx_data changing mid-frame has no effect; the latched copy is used.
- No X on any output after the first reset edge.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP} (2-bit encoding);
  - default constants CLK_HZ=100_000_000, BAUD=9600, DEFAULT_CLKS_PER_BIT.
- The receiver reuses the package.
- One natural sub-module: baud_tick.
  - Holds the CLKS_PER_BIT counter with a synchronous clear.
  - Outputs a tick on the last count.
  - The receiver reuses it.
- The FSM and shift register stay in uart_tx.

Test Plan (bench uses CLKS_PER_BIT=4, DATA_BITS=8; clk period 20 ns, matching the existing DFF bench):
- Reset hold: reset=0 for 3 edges, tx_start=1 -> tx=1, tx_busy=0, tx_done=0 throughout; no frame starts until reset=1.
- Single frame 0xA5:
  - Stimulus: 1-cycle tx_start pulse.
  - Expected tx sequence: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - tx_busy high for 40 cycles.
  - tx_done high exactly once, on cycle 40 after the accept.
- Busy ignore:
  - Stimulus: send 0x3C, pulse tx_start with 0xFF at cycle 10.
  - Expected: frame bits remain 0,0,1,1,1,1,0,0; no second frame.
- Back-to-back: tx_start held high with tx_data=0x00 -> two frames with exactly 1 idle cycle (tx=1, tx_busy=0) between them; 2 tx_done pulses 41 cycles apart.
- Reset mid-frame:
  - Stimulus: reset=0 at cycle 18 of a 0x55 frame.
  - Expected: tx=1 and tx_busy=0 on that edge; no tx_done; the next tx_start sends a clean full frame.
- Data stability: change tx_data every cycle during a 0x81 frame -> serialized bits 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the lab UART link (transmitter and receiver).
//   state_t              : frame FSM states, 2-bit encoding
//   CLK_HZ, BAUD         : board clock and link baud rate
//   DEFAULT_CLKS_PER_BIT : rounded CLK_HZ / BAUD (10417 for 100 MHz / 9600)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int CLK_HZ = 100_000_000;
    localparam int BAUD   = 9600;
    // Round to nearest rather than truncate so the bit period error stays small.
    localparam int DEFAULT_CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter shared by the UART transmitter and receiver.
//   clk, reset : clock and synchronous active-low reset
//   clear      : synchronous clear of the count (priority over enable)
//   enable     : count while high; hold while low
//   tick       : high on the last count (CLKS_PER_BIT-1) while enabled;
//                the counter wraps to 0 on the following edge
module baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_reg;

    assign tick = enable && (count_reg == LAST);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= tick ? '0 : count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fixed baud from CLKS_PER_BIT.
//   clk      : system clock, rising edge
//   reset    : synchronous active-low reset
//   tx_data  : payload, latched only on the accept edge
//   tx_start : send request; held high it resends once per frame
//   tx_busy  : high while a frame is in progress
//   tx_done  : one-cycle pulse on the final cycle of the stop bit
//   tx       : serial line, idle high, driven straight from a flop
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    state_t               state_reg,   state_next;
    logic [DATA_BITS-1:0] shift_reg,   shift_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic                 tx_reg,      tx_next;
    logic                 busy_reg,    busy_next;
    logic                 accept;
    logic                 tick;
    logic [DATA_BITS-1:0] shift_shr;

    assign accept    = (state_reg == IDLE) && tx_start;
    assign shift_shr = shift_reg >> 1;

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (state_reg != IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
        end
    end

    // The line value for the next bit is computed here so tx is a pure flop.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        tx_next      = tx_reg;
        busy_next    = busy_reg;
        unique case (state_reg)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (tx_start) begin
                    shift_next = tx_data;
                    state_next = START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    tx_next      = shift_reg[0];
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        shift_next   = shift_shr;
                        tx_next      = shift_shr[0];
                        bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx      = tx_reg;
    assign tx_busy = busy_reg;
    // Decoded from registered state and count, so it is glitch-free in practice.
    assign tx_done = (state_reg == STOP) && tick;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int NBITS = 8;
    localparam int FLEN  = (NBITS + 2) * CPB;   // 40 busy cycles per frame

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (NBITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx       (tx)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         abort;    // frame is expected to be cut short by reset
        bit         gap_chk;  // frame must follow the previous after 1 idle cycle
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle_cnt = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Hand-written line image: 4 cycles start, 8 bits x 4 cycles LSB first, 4 cycles stop.
    function automatic logic [FLEN-1:0] exp_line(input logic [7:0] d);
        logic [FLEN-1:0] v;
        for (int i = 0; i < FLEN; i++) begin
            if (i < CPB)                v[i] = 1'b0;
            else if (i < FLEN - CPB)    v[i] = d[(i - CPB) / CPB];
            else                        v[i] = 1'b1;
        end
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit              in_frame = 0;
    int              fcyc = 0;
    int              idle_cnt = 0;
    int              gap = 0;
    int              this_done = -1;
    int              last_done = -1;
    logic [FLEN-1:0] line_v;
    logic [FLEN-1:0] done_v;

    task automatic end_frame();
        exp_t e;
        logic [FLEN-1:0] done_exp;
        done_exp = '0;
        done_exp[FLEN-1] = 1'b1;
        if (exp_q.size() == 0) begin
            check("unexpected_frame", 64'(line_v), 64'hx);
        end else begin
            e = exp_q.pop_front();
            if (e.abort) begin
                check("abort_short", 64'(fcyc < FLEN), 64'd1);
                check("abort_no_done", 64'(done_v), 64'd0);
            end else begin
                check("frame_len", 64'(fcyc), 64'(FLEN));
                check("frame_line", 64'(line_v), 64'(exp_line(e.data)));
                check("done_pos", 64'(done_v), 64'(done_exp));
                if (e.gap_chk) begin
                    check("idle_gap", 64'(gap), 64'd1);
                    check("done_spacing", 64'(this_done - last_done), 64'(FLEN + 1));
                end
                $display("[TB] frame %02h checked (%0d cycles)", e.data, fcyc);
            end
        end
        if (this_done >= 0) last_done = this_done;
    endtask

    always @(negedge clk) begin
        if (tx_busy === 1'b1) begin
            if (!in_frame) begin
                in_frame  = 1;
                fcyc      = 0;
                line_v    = '1;
                done_v    = '0;
                gap       = idle_cnt;
                this_done = -1;
            end
            if (fcyc < FLEN) begin
                line_v[fcyc] = tx;
                done_v[fcyc] = tx_done;
            end
            if (tx_done === 1'b1) this_done = cycle_cnt;
            fcyc++;
            idle_cnt = 0;
        end else if (cycle_cnt > 0) begin
            if (in_frame) begin
                in_frame = 0;
                end_frame();
            end
            check("idle_tx", 64'(tx), 64'd1);
            check("idle_done", 64'(tx_done), 64'd0);
            idle_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [7:0] d, input bit ab, input bit gc);
        exp_t e;
        e.data = d; e.abort = ab; e.gap_chk = gc;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d);
        push(d, 0, 0);
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset hold with a pending request: nothing may start.
        reset    = 1'b0;
        tx_start = 1'b1;
        tx_data  = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_tx", 64'(tx), 64'd1);
            check("rst_busy", 64'(tx_busy), 64'd0);
            check("rst_done", 64'(tx_done), 64'd0);
        end
        $display("[TB] reset hold done");
        push(8'h5A, 0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        check("accept_latency_tx", 64'(tx), 64'd0);
        check("accept_busy", 64'(tx_busy), 64'd1);
        wait_cycles(45);

        // Single frame 0xA5.
        send(8'hA5);
        wait_cycles(45);

        // Request while busy is ignored.
        send(8'h3C);
        wait_cycles(9);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        wait_cycles(45);

        // Held request: two frames, one idle cycle apart.
        push(8'h00, 0, 0);
        push(8'h00, 0, 1);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        wait_cycles(42);
        tx_start = 1'b0;
        wait_cycles(45);

        // Reset mid-frame aborts with no done, then a clean frame.
        push(8'h55, 1, 0);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        repeat (17) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_tx", 64'(tx), 64'd1);
        check("midrst_busy", 64'(tx_busy), 64'd0);
        check("midrst_done", 64'(tx_done), 64'd0);
        reset = 1'b1;
        wait_cycles(3);
        send(8'h55);
        wait_cycles(45);

        // tx_data churns during the frame; the latched byte is sent.
        send(8'h81);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            tx_data = 8'($urandom);
        end
        wait_cycles(8);

        check("frames_outstanding", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
